// File: rtl/mips_pkg.sv
// Shared MIPS core package: word width, reset PC, PC step, fetch buffer
// entry type, fetch buffer occupancy states, and the opcode/funct constants
// that ctrl decodes.
package mips_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Opcode / funct constants consumed by ctrl
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // One buffered instruction together with the byte PC it was fetched from
  typedef struct packed {
    logic [WORD_W-1:0] cmd;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid : buffer head holds a valid instruction (fetch -> decode)
//   out_ready : decode accepts the head this cycle    (decode -> fetch)
//   out_cmd   : instruction word at the head          (fetch -> decode)
//   out_pc    : byte PC of out_cmd                    (fetch -> decode)
interface fetch_unit_if;
  import mips_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_cmd;
  logic [WORD_W-1:0] out_pc;

  modport master (output out_valid, output out_cmd, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_cmd, input out_pc, output out_ready);
endinterface

// File: rtl/inst_fifo.sv
// Instruction buffer: DEPTH entries of {cmd, pc}.
//   clk/reset : core clock, synchronous active-high reset (clears storage)
//   push/din  : write din at the tail
//   pop       : drop the head
//   flush     : empty the buffer (pointers and count only; storage kept)
//   head      : registered head entry, stale contents when empty
//   full/empty: occupancy flags
module inst_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic [CW-1:0]  count;
  fifo_state_e    state;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state = FIFO_PARTIAL;
    if (count == '0)               state = FIFO_EMPTY;
    else if (count == CW'(DEPTH))  state = FIFO_FULL;
  end

  assign full  = (state == FIFO_FULL);
  assign empty = (state == FIFO_EMPTY);
  assign head  = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, addresses imem, and buffers
// fetched {instruction, PC} pairs for decode over a valid/ready handshake.
//   clk/reset      : core clock, synchronous active-high reset
//   imem_addr      : word address into imem, taken from fpc
//   imem_data      : same-cycle instruction read of imem_addr
//   redirect_valid : flush buffer and restart fetch at redirect_pc
//   redirect_pc    : target byte address (low two bits ignored)
//   dec            : out_valid/out_ready/out_cmd/out_pc handshake to decode
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_AW  = 6,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [WORD_W-1:0]   imem_data,
  input  logic                redirect_valid,
  input  logic [WORD_W-1:0]   redirect_pc,
  fetch_unit_if.master        dec
);

  logic [WORD_W-1:0] fpc;
  logic              deq;
  logic              enq;
  logic              full;
  logic              empty;
  fetch_entry_t      head;
  fetch_entry_t      din;

  assign deq = dec.out_valid & dec.out_ready;
  // A pop in the same cycle frees a slot, so a full buffer can still accept
  assign enq = ~reset & ~redirect_valid & (~full | deq);
  assign din = '{cmd: imem_data, pc: fpc};

  always_ff @(posedge clk) begin
    if (reset)               fpc <= RESET_PC;
    else if (redirect_valid) fpc <= redirect_pc & ~32'h3;
    else if (enq)            fpc <= fpc + PC_STEP;
  end

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr     = fpc[IMEM_AW+1:2];
  assign dec.out_valid = ~empty;
  assign dec.out_cmd   = head.cmd;
  assign dec.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 64-word imem holding 32'hA000_0000+i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem [64];

  int checks = 0;
  int errors = 0;

  fetch_unit_if ifc ();

  fetch_unit #(.IMEM_AW(6), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (ifc.master)
  );

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] cmd, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, ifc.out_valid}, {31'd0, v});
    chk({tag, "_cmd"}, ifc.out_cmd, cmd);
    chk({tag, "_pc"}, ifc.out_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | i;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ifc.out_ready = 1'b1;
    step(); step();
    head("rst", 1'b0, 32'h0, 32'h0);
    chk("rst_addr", {26'd0, imem_addr}, 32'd0);

    // Streaming with decode always ready
    reset = 1'b0;
    step(); head("s0", 1'b1, 32'hA000_0000, 32'h0);
    step(); head("s1", 1'b1, 32'hA000_0001, 32'h4);
    step(); head("s2", 1'b1, 32'hA000_0002, 32'h8);

    // Backpressure from empty: fills to 2, fpc holds at 8
    reset = 1'b1; step();
    reset = 1'b0; ifc.out_ready = 1'b0;
    repeat (5) step();
    head("bp", 1'b1, 32'hA000_0000, 32'h0);
    chk("bp_addr", {26'd0, imem_addr}, 32'd2);
    ifc.out_ready = 1'b1;
    step(); head("rel1", 1'b1, 32'hA000_0001, 32'h4);
    step(); head("rel2", 1'b1, 32'hA000_0002, 32'h8);

    // Redirect while full
    ifc.out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0014;
    step();
    chk("rd_bubble", {31'd0, ifc.out_valid}, 32'd0);
    chk("rd_addr", {26'd0, imem_addr}, 32'd5);
    redirect_valid = 1'b0; ifc.out_ready = 1'b1;
    step(); head("rd_tgt", 1'b1, 32'hA000_0005, 32'h14);

    // Misaligned redirect with a simultaneous handshake
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    chk("mis_bubble", {31'd0, ifc.out_valid}, 32'd0);
    chk("mis_addr", {26'd0, imem_addr}, 32'd4);
    redirect_valid = 1'b0;
    step(); head("mis_tgt", 1'b1, 32'hA000_0004, 32'h10);

    // Reset overrides a redirect in the same cycle
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    step();
    head("rr", 1'b0, 32'h0, 32'h0);
    chk("rr_addr", {26'd0, imem_addr}, 32'd0);
    reset = 1'b0; redirect_valid = 1'b0;
    step(); head("rr_first", 1'b1, 32'hA000_0000, 32'h0);

    // Word-address wrap past the top of imem
    redirect_valid = 1'b1; redirect_pc = 32'h0000_00FC;
    step();
    chk("wr_addr63", {26'd0, imem_addr}, 32'd63);
    redirect_valid = 1'b0;
    step(); head("wr_top", 1'b1, 32'hA000_003F, 32'hFC);
    chk("wr_addr0", {26'd0, imem_addr}, 32'd0);
    step(); head("wr_next", 1'b1, 32'hA000_0000, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
